// File: rtl/rr_sel_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_sel_arbiter_4
//  Description : Four-channel round-robin arbiter feeding a 4:1 mux stage.
//                Picks one requesting channel per transfer, captures its word
//                and select index into a one-entry output register, and
//                presents it downstream on a valid/ready interface.
//  Ports       : clk        - clock, all state updates on rising edge
//                rst        - asynchronous active-high reset
//                req[3:0]   - per-channel request (d<i> holds a valid word)
//                d0..d3     - channel data words, W bits each
//                gnt[3:0]   - combinational one-hot accept; word i transfers
//                             when req[i] && gnt[i] at a rising edge
//                out_valid  - out_data/out_sel hold a word
//                out_ready  - downstream accepts this cycle
//                out_data   - registered captured word
//                out_sel    - registered source index (mux select)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_sel_arbiter_4 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   output logic [3:0]   gnt,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   out_sel
);

   logic [1:0]   r_ptr;
   logic         r_valid;
   logic [W-1:0] r_data;
   logic [1:0]   r_sel;

   logic         w_load;
   logic         w_found;
   logic [1:0]   w_idx;
   logic [1:0]   w_ch;
   logic         w_grant;
   logic [W-1:0] w_sel_data;

   // Register can take a new word when empty or being drained this cycle.
   assign w_load = !r_valid || out_ready;

   // Scan channels starting at the priority pointer; the 2-bit add wraps
   // naturally, so the first hit in scan order wins.
   always_comb begin
      w_found = 1'b0;
      w_idx   = 2'd0;
      w_ch    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_ch = r_ptr + 2'(k);
         if (!w_found && req[w_ch]) begin
            w_found = 1'b1;
            w_idx   = w_ch;
         end
      end
   end

   // Gated by rst so no accept is advertised while the block is held in reset.
   assign w_grant = w_found && w_load && !rst;
   assign gnt     = w_grant ? (4'b0001 << w_idx) : 4'b0000;

   // Explicit decode so only the selected channel can reach the register.
   always_comb begin
      w_sel_data = d0;
      case (w_idx)
         2'd0:    w_sel_data = d0;
         2'd1:    w_sel_data = d1;
         2'd2:    w_sel_data = d2;
         default: w_sel_data = d3;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= 2'd0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= 2'd0;
      end else if (w_grant) begin
         r_data  <= w_sel_data;
         r_sel   <= w_idx;
         r_valid <= 1'b1;
         r_ptr   <= w_idx + 2'd1;
      end else if (w_load) begin
         // Nothing requested: drain (if holding) and keep data/sel/ptr.
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: doc/rr_sel_arbiter_4.md
Name: rr_sel_arbiter_4

Overview:
- Four-channel round-robin arbiter that sits directly upstream of the 4:1 mux stage.
- Picks one requesting channel per transfer and produces the 2-bit select for the mux.
- Captures the selected 4-bit word into a one-entry output register, together with its select index.
- Presents the word downstream on a valid/ready interface.
- Gives each channel a one-cycle accept (gnt) when its word is taken.

Parameters:
- W, 4, data width of each channel word and of out_data.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-channel request; req[i] means d<i> holds a valid word.
- d0  input  W  channel 0 data.
- d1  input  W  channel 1 data.
- d2  input  W  channel 2 data.
- d3  input  W  channel 3 data.
- gnt  output  4  combinational, at most one bit set; a word transfers from channel i when req[i] && gnt[i] at a rising edge.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  W  registered captured word.
- out_sel  output  2  registered index of the channel that supplied out_data; this is the mux select.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. ptr is the 2-bit internal priority pointer.
- While rst=1, gnt=0.
- load = !out_valid || out_ready. The register is empty, or it is being drained this cycle.
- Grant selection, only when load=1:
  - Scan channels ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first channel i with req[i]=1 gets gnt[i]=1.
  - If no req bit is set, gnt=0.
- When load=0, gnt=0 regardless of req.
- Rising edge with load=1 and a grant to channel i:
  - out_data <= d<i>, out_sel <= i, out_valid <= 1.
  - ptr <= (i+1) mod 4. 3 wraps to 0.
- Rising edge with load=1 and no req:
  - out_valid <= 0. If out_valid was 1, the word is drained.
  - out_data and out_sel keep their last values.
  - ptr unchanged.
- Rising edge with load=0 (out_valid=1, out_ready=0): out_data, out_sel and ptr all hold.
- Simultaneous drain and refill: out_valid=1 with out_ready=1 and a req present.
  - The new word is captured in the same edge.
  - out_valid stays 1, giving full throughput of one word per cycle.
- Latency: a granted word appears on out_data exactly one cycle after its gnt cycle.
- gnt is a pure function of req, ptr, out_valid and out_ready. No combinational path from d* to gnt.
- X on unselected d* inputs must not propagate to out_data.
- X on the selected d<i> passes through unchanged. The bench compares with !==.
- Fairness: with all four req held high and out_ready=1, grants rotate 0,1,2,3,0,...
  - Any continuously requesting channel is granted within 4 transfers.
- Mid-operation reset:
  - rst asserted at any time clears out_valid and ptr immediately, without waiting for clk.
  - Any pending word is dropped.
  - After rst falls, the first grant starts scanning from channel 0.
- req[i] may drop without a grant; nothing is stored for it.

Test Plan:
- Single requester: rst pulse, then req=4'b0100, d2=4'hc, out_ready=1. Expect gnt=4'b0100 that cycle; next cycle out_valid=1, out_data=4'hc, out_sel=2; ptr becomes 3.
- Rotation: d0..d3=a,b,c,d, req=4'b1111, out_ready=1 for 5 cycles. Expect out_sel 0,1,2,3,0 and out_data a,b,c,d,a on consecutive cycles, with out_valid=1 throughout.
- Backpressure: out_valid=1 with out_data=4'h7, out_sel=0, then out_ready=0 for 3 cycles with req=4'b0010. Expect gnt=0; out_data=7 and out_sel=0 held. Raise out_ready: gnt=4'b0010 that cycle; next cycle out_data=d1, out_sel=1.
- Wrap and skip: ptr=3, req=4'b0011. Expect gnt=4'b0001 and out_sel=0, then ptr=1; the next grant goes to channel 1.
- X isolation: d0=7, d1=10, d2=3, d3='x, granting channels 0,1,2 then 3. Expect out_data 7,10,3 exactly, then 'x.
- Async reset mid-stream: during the rotation test, assert rst between clock edges. Expect out_valid=0 and gnt=0 immediately. Release rst with req=4'b1111: the first out_sel=0.
